microop_sequencer: RTL and testbench
====================================

Name: microop_sequencer

Overview:
Sequences the microcode store by owning the opcode register, the micro-op counter and the condition-variable latch. It drives the 12-bit microcode address ADDR = {cond_var, opcode, microop_count}. It consumes the control fields of the returned microcode word to advance, reset or redirect the sequence. It sits between the microcode LUT and the datapath planes, and gates plane writes during stalls and faults.

Parameters:
OPCODE_W, 6, opcode register width; ADDR bits [10:5]
COUNT_W, 5, micro-op counter width; ADDR bits [4:0]
RESET_OPCODE, 0, opcode loaded on reset (OP_RESET)
ADDR_W, 12, 1+OPCODE_W+COUNT_W; fixed, not overridable

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
UCODE  in  32  current microcode word; fields: [16:14] in_plane, [17] misc reset-counter, [25] opcode_sel, [27:26] cond_var_sel
BUS  in  32  datapath bus; [5:0] is the opcode source when opcode_sel=1
OPWORD  in  32  opword register; [31:26] is the opcode source when opcode_sel=0
MLU_ZERO  in  1  MLU zero flag
MLU_CARRY  in  1  MLU carry flag
MLU_NEG  in  1  MLU negative flag
INTERRUPT  in  1  level interrupt request, synchronous to CLK
WAIT  in  1  stall request from MMU/timer; holds the sequence
ADDR  out  12  microcode address {cond_var, opcode, count}
PLANE_EN  out  1  write-enable qualifier for every in_plane target
INT_ACK  out  1  one-cycle pulse when a pending interrupt is consumed
FAULT  out  1  sticky; micro-op counter overflowed

Behaviour:
- States: INIT, RUN, FAULT.
- RST high: state=INIT, opcode=RESET_OPCODE, count=0, cond_var=0, int_pending=0. Outputs during reset: ADDR=0x000, PLANE_EN=0, INT_ACK=0, FAULT=0.
- INIT: lasts exactly one cycle after RST deasserts, so the LUT output settles. Registers are held and PLANE_EN=0. The state then moves to RUN.
- PLANE_EN = (state==RUN) && !WAIT. It is combinational and has no latency.
- RUN with WAIT=1: opcode, count, cond_var and state all hold. int_pending may still be set.
- RUN with WAIT=0, all updates take effect on the next clock edge:
  - count <= UCODE[17] ? 0 : count+1.
  - If UCODE[16:14]==6 (IN_OPCODE): opcode <= UCODE[25] ? BUS[5:0] : OPWORD[31:26]. Otherwise opcode holds.
  - cond_var <= selected source, per UCODE[27:26]: 0 = MLU_ZERO, 1 = MLU_CARRY, 2 = MLU_NEG, 3 = int_pending. It is rewritten every advancing cycle, so its value is valid only for the next micro-op.
  - If UCODE[27:26]==3 and int_pending==1: INT_ACK=1 in that cycle (combinational), and int_pending clears on the edge.
- int_pending is set on any edge where INTERRUPT=1. This happens in all states except during RST. Set wins over a simultaneous clear, so the interrupt is re-pended with no ACK loss.
- Overflow: RUN, WAIT=0, count==31 and UCODE[17]==0 → state <= FAULT. In this case count does not wrap.
- FAULT: all registers frozen and ADDR holds its last value. PLANE_EN=0 and FAULT=1. Only RST exits FAULT.
- A reset counter (UCODE[17]=1) at count 31 is legal and does not fault.
- Reset mid-sequence: asynchronous. All registers clear immediately, regardless of WAIT or state.
- ADDR is the registered {cond_var, opcode, count}, with no combinational path from UCODE.

Test Plan:
- Reset/boot: assert RST, release. Required: ADDR=0x000 and PLANE_EN=0 for one cycle (INIT), then PLANE_EN=1 with ADDR=0x000.
- GO_FETCH: at count 1, drive UCODE[17]=1, [16:14]=6, [25]=1, BUS=1. Required: next ADDR=0x020.
- Opcode from opword: at ADDR=0x024, drive UCODE[16:14]=6, [17]=1, [25]=0, OPWORD=0x20000000 (opcode 8). Required: next ADDR=0x100.
- Condition: at ADDR=0x102, drive UCODE[27:26]=0, MLU_ZERO=1. Required: next ADDR=0x903. Repeat with MLU_ZERO=0. Required: next ADDR=0x103.
- Stall: hold WAIT=1 for 3 cycles at ADDR=0x101. Required: ADDR stays 0x101 and PLANE_EN=0 during the stall; after release the next ADDR=0x102.
- Interrupt/fault: pulse INTERRUPT 1 cycle, then drive UCODE[27:26]=3. Required: INT_ACK=1 for one cycle and cond_var=1 in the next ADDR.
- Fault: run 32 advancing cycles with UCODE[17]=0. Required: FAULT=1, PLANE_EN=0, ADDR frozen at count 31 until RST.

Source files
------------

// File: rtl/microop_sequencer.sv
// microop_sequencer: owns opcode, micro-op counter and condition latch; drives the microcode address
//   CLK        system clock, rising edge
//   RST        asynchronous reset, active-high
//   UCODE      microcode word: [16:14] in_plane, [17] reset counter, [25] opcode_sel, [27:26] cond_var_sel
//   BUS        datapath bus, [OPCODE_W-1:0] is the opcode source when opcode_sel=1
//   OPWORD     opword register, top OPCODE_W bits are the opcode source when opcode_sel=0
//   MLU_ZERO   MLU zero flag
//   MLU_CARRY  MLU carry flag
//   MLU_NEG    MLU negative flag
//   INTERRUPT  level interrupt request
//   WAIT       stall request, holds the sequence
//   ADDR       registered microcode address {cond_var, opcode, count}
//   PLANE_EN   write-enable qualifier for plane targets
//   INT_ACK    pulse when a pending interrupt is consumed
//   FAULT      sticky counter-overflow indication
module microop_sequencer #(
    parameter int OPCODE_W = 6,
    parameter int COUNT_W = 5,
    parameter int RESET_OPCODE = 0,
    localparam int ADDR_W = 1 + OPCODE_W + COUNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       UCODE,
    input  logic [31:0]       BUS,
    input  logic [31:0]       OPWORD,
    input  logic              MLU_ZERO,
    input  logic              MLU_CARRY,
    input  logic              MLU_NEG,
    input  logic              INTERRUPT,
    input  logic              WAIT,
    output logic [ADDR_W-1:0] ADDR,
    output logic              PLANE_EN,
    output logic              INT_ACK,
    output logic              FAULT
);
    typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

    state_t              state, state_n;
    logic [OPCODE_W-1:0] opcode, opcode_n;
    logic [COUNT_W-1:0]  count, count_n;
    logic                cond_var, cond_n;
    logic                int_pending, pend_n;
    logic                cond_src;
    logic                advance;
    logic                overflow;
    logic                unused_bits;

    assign unused_bits = ^{UCODE[31:28], UCODE[24:18], UCODE[13:0], BUS[31:OPCODE_W], OPWORD[31-OPCODE_W:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_INIT;
            opcode      <= OPCODE_W'(RESET_OPCODE);
            count       <= '0;
            cond_var    <= 1'b0;
            int_pending <= 1'b0;
        end else begin
            state       <= state_n;
            opcode      <= opcode_n;
            count       <= count_n;
            cond_var    <= cond_n;
            int_pending <= pend_n;
        end
    end

    always_comb begin
        cond_src = UCODE[27] ? (UCODE[26] ? int_pending : MLU_NEG) : (UCODE[26] ? MLU_CARRY : MLU_ZERO);
        advance  = (state == S_RUN) && !WAIT;
        // overflow freezes every register; only the state moves to FAULT
        overflow = advance && !UCODE[17] && (count == {COUNT_W{1'b1}});
        state_n  = state == S_INIT ? S_RUN : (overflow ? S_FAULT : state);
        opcode_n = opcode;
        count_n  = count;
        cond_n   = cond_var;
        INT_ACK  = 1'b0;
        if (advance && !overflow) begin
            count_n  = UCODE[17] ? '0 : count + 1'b1;
            opcode_n = UCODE[16:14] == 3'd6 ? (UCODE[25] ? BUS[OPCODE_W-1:0] : OPWORD[31 -: OPCODE_W]) : opcode;
            cond_n   = cond_src;
            INT_ACK  = (UCODE[27:26] == 2'd3) && int_pending;
        end
        // a new request on the consuming edge re-pends, so set wins over clear
        pend_n   = (int_pending && !INT_ACK) || INTERRUPT;
        PLANE_EN = advance;
        FAULT    = state == S_FAULT;
        ADDR     = {cond_var, opcode, count};
    end
endmodule

// File: tb/tb_microop_sequencer.sv
// tb_microop_sequencer: directed stimulus with a behavioural address-sequence model and per-cycle compare
module tb_microop_sequencer;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] UCODE = '0;
    logic [31:0] BUS = '0;
    logic [31:0] OPWORD = '0;
    logic        MLU_ZERO = 1'b0;
    logic        MLU_CARRY = 1'b0;
    logic        MLU_NEG = 1'b0;
    logic        INTERRUPT = 1'b0;
    logic        WAIT = 1'b0;
    logic [11:0] ADDR;
    logic        PLANE_EN;
    logic        INT_ACK;
    logic        FAULT;

    int checks = 0;
    int failures = 0;

    microop_sequencer dut (
        .CLK(CLK), .RST(RST), .UCODE(UCODE), .BUS(BUS), .OPWORD(OPWORD),
        .MLU_ZERO(MLU_ZERO), .MLU_CARRY(MLU_CARRY), .MLU_NEG(MLU_NEG),
        .INTERRUPT(INTERRUPT), .WAIT(WAIT), .ADDR(ADDR), .PLANE_EN(PLANE_EN),
        .INT_ACK(INT_ACK), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    // model: phase 0=init, 1=run, 2=fault
    int m_phase;
    int m_op;
    int m_cnt;
    int m_cond;
    int m_pend;

    function automatic int sel_flag();
        int s;
        s = int'(UCODE[27:26]);
        return s == 0 ? int'(MLU_ZERO) : s == 1 ? int'(MLU_CARRY) : s == 2 ? int'(MLU_NEG) : m_pend;
    endfunction

    function automatic bit m_adv();
        return m_phase == 1 && !WAIT;
    endfunction

    function automatic bit m_ovf();
        return m_adv() && !UCODE[17] && m_cnt == 31;
    endfunction

    function automatic bit m_ack();
        return m_adv() && !m_ovf() && UCODE[27:26] == 2'd3 && m_pend == 1;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase = 0; m_op = 0; m_cnt = 0; m_cond = 0; m_pend = 0;
        end else begin
            int nc;
            int np;
            np = m_pend;
            if (m_phase == 0) m_phase = 1;
            else if (m_ovf()) m_phase = 2;
            else if (m_adv()) begin
                nc = sel_flag();
                if (m_ack()) np = 0;
                m_cnt = UCODE[17] ? 0 : (m_cnt + 1) % 32;
                if (UCODE[16:14] == 3'd6) m_op = UCODE[25] ? int'(BUS[5:0]) : int'(OPWORD[31:26]);
                m_cond = nc;
            end
            m_pend = (np == 1 || INTERRUPT) ? 1 : 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("model_addr", {20'd0, ADDR}, 32'(m_cond * 2048 + m_op * 32 + m_cnt));
        check("model_plane_en", {31'd0, PLANE_EN}, {31'd0, m_adv()});
        check("model_int_ack", {31'd0, INT_ACK}, {31'd0, m_ack()});
        check("model_fault", {31'd0, FAULT}, {31'd0, m_phase == 2});
    end

    localparam logic [31:0] RCNT = 32'h0002_0000;
    localparam logic [31:0] INOP = 32'h0001_8000;
    localparam logic [31:0] SBUS = 32'h0200_0000;
    localparam logic [31:0] SINT = 32'h0C00_0000;

    task automatic step(input logic [31:0] u);
        UCODE = u;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        @(posedge CLK); @(posedge CLK); #1;
        check("reset_addr", {20'd0, ADDR}, 32'h000);
        check("reset_plane_en", {31'd0, PLANE_EN}, 32'd0);
        RST = 1'b0;
        check("init_plane_en", {31'd0, PLANE_EN}, 32'd0);
        @(posedge CLK); #1;
        check("run_plane_en", {31'd0, PLANE_EN}, 32'd1);
        check("run_addr", {20'd0, ADDR}, 32'h000);
        step(32'd0);
        check("count1", {20'd0, ADDR}, 32'h001);
        BUS = 32'd1;
        step(RCNT | INOP | SBUS);
        check("go_fetch", {20'd0, ADDR}, 32'h020);
        repeat (4) step(32'd0);
        check("pre_opword", {20'd0, ADDR}, 32'h024);
        OPWORD = 32'h2000_0000;
        step(RCNT | INOP);
        check("opword", {20'd0, ADDR}, 32'h100);
        step(32'd0);
        WAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            UCODE = RCNT | INOP | SBUS;
            #1;
            check("stall_plane_en", {31'd0, PLANE_EN}, 32'd0);
            @(posedge CLK); #1;
            check("stall_addr", {20'd0, ADDR}, 32'h101);
        end
        WAIT = 1'b0;
        step(32'd0);
        check("stall_release", {20'd0, ADDR}, 32'h102);
        MLU_ZERO = 1'b1;
        step(32'd0);
        check("cond_zero1", {20'd0, ADDR}, 32'h903);
        MLU_ZERO = 1'b0;
        step(32'd0);
        check("cond_zero0", {20'd0, ADDR}, 32'h104);
        MLU_CARRY = 1'b1;
        step(32'h0400_0000);
        check("cond_carry", {20'd0, ADDR}, 32'h905);
        MLU_CARRY = 1'b0;
        INTERRUPT = 1'b1;
        step(32'd0);
        INTERRUPT = 1'b0;
        check("int_pend_addr", {20'd0, ADDR}, 32'h106);
        UCODE = SINT;
        #1;
        check("int_ack_pulse", {31'd0, INT_ACK}, 32'd1);
        @(posedge CLK); #1;
        check("int_cond", {20'd0, ADDR}, 32'h907);
        UCODE = SINT;
        #1;
        check("int_ack_cleared", {31'd0, INT_ACK}, 32'd0);
        @(posedge CLK); #1;
        check("int_cond_clear", {20'd0, ADDR}, 32'h108);
        INTERRUPT = 1'b1;
        step(32'd0);
        step(SINT);
        INTERRUPT = 1'b0;
        UCODE = SINT;
        #1;
        check("int_repend_ack", {31'd0, INT_ACK}, 32'd1);
        @(posedge CLK); #1;
        check("int_repend_addr", {20'd0, ADDR}, 32'h90B);
        while (ADDR[4:0] != 5'd31) step(32'd0);
        step(RCNT);
        check("reset_at_31", {20'd0, ADDR}, 32'h100);
        check("no_fault_at_31", {31'd0, FAULT}, 32'd0);
        repeat (32) step(32'd0);
        check("fault_set", {31'd0, FAULT}, 32'd1);
        check("fault_plane_en", {31'd0, PLANE_EN}, 32'd0);
        check("fault_addr", {20'd0, ADDR}, 32'h11F);
        BUS = 32'd5;
        MLU_ZERO = 1'b1;
        INTERRUPT = 1'b1;
        repeat (3) step(RCNT | INOP | SBUS);
        INTERRUPT = 1'b0;
        check("fault_frozen", {20'd0, ADDR}, 32'h11F);
        check("fault_sticky", {31'd0, FAULT}, 32'd1);
        RST = 1'b1;
        #1;
        check("async_reset_addr", {20'd0, ADDR}, 32'h000);
        check("async_reset_fault", {31'd0, FAULT}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        check("reboot_plane_en", {31'd0, PLANE_EN}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
